// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave transaction controller (header, data words, optional burst)
module spi_slave_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int BURST_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       sclk_pos,
    input  logic       sclk_neg,
    input  logic       rw,
    output logic       shift_wren,
    output logic       shift_out,
    output logic       sr_load,
    output logic       addr_wren,
    output logic       addr_inc,
    output logic       dm_wren,
    output logic       miso_en,
    output logic [7:0] word_cnt,
    output logic [2:0] state
);

    localparam int HDR_W = ADDR_W + 1;
    localparam int MAX_W = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic             BURST     = (BURST_EN != 0);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_RD_LOAD   = 3'd3;
    localparam logic [2:0] S_RD_SHIFT  = 3'd4;
    localparam logic [2:0] S_WR_SHIFT  = 3'd5;
    localparam logic [2:0] S_WR_COMMIT = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic             counting;
    logic             hdr_done;
    logic             rd_done;
    logic             wr_done;
    logic             word_done;

    assign counting  = (state_q == S_ADDR) || (state_q == S_RD_SHIFT) || (state_q == S_WR_SHIFT);
    assign hdr_done  = (state_q == S_ADDR)     && sclk_pos && (bit_cnt == HDR_LAST);
    assign rd_done   = (state_q == S_RD_SHIFT) && sclk_pos && (bit_cnt == DATA_LAST);
    assign wr_done   = (state_q == S_WR_SHIFT) && sclk_pos && (bit_cnt == DATA_LAST);
    // A read word only counts if CS is still low; a raised CS discards it.
    assign word_done = (rd_done && !cs_n) || (state_q == S_WR_COMMIT);

    always_comb begin
        state_d = state_q;
        if (cs_n) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      state_d = S_ADDR;
                S_ADDR:      if (hdr_done) state_d = S_DECODE;
                S_DECODE:    state_d = rw ? S_RD_LOAD : S_WR_SHIFT;
                S_RD_LOAD:   state_d = S_RD_SHIFT;
                S_RD_SHIFT:  if (rd_done) state_d = BURST ? S_RD_LOAD : S_DONE;
                S_WR_SHIFT:  if (wr_done) state_d = S_WR_COMMIT;
                S_WR_COMMIT: state_d = BURST ? S_WR_SHIFT : S_DONE;
                S_DONE:      state_d = S_DONE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bit_cnt  <= '0;
            word_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                bit_cnt <= '0;
            end else if (counting && sclk_pos) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (state_q == S_IDLE && state_d == S_ADDR) begin
                word_cnt <= 8'd0;
            end else if (word_done && word_cnt != 8'hFF) begin
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end

    assign shift_wren = sclk_pos && ((state_q == S_ADDR) || (state_q == S_WR_SHIFT));
    assign shift_out  = sclk_neg && (state_q == S_RD_SHIFT);
    assign sr_load    = (state_q == S_RD_LOAD);
    assign addr_wren  = (state_q == S_DECODE);
    assign dm_wren    = (state_q == S_WR_COMMIT);
    assign miso_en    = (state_q == S_RD_SHIFT);
    assign addr_inc   = BURST && word_done;
    assign state      = state_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - self-checking bench for spi_slave_ctrl against a transaction-level model
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_pos = 1'b0;
    logic       sclk_neg = 1'b0;
    logic       rw = 1'b0;
    logic [2:0] cs_n = 3'b111;

    logic [2:0] sw, so, srl, aw, inc, dm, me;
    logic [7:0] wc [3];
    logic [2:0] st [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // dut0: defaults without burst, dut1: defaults with burst, dut2: wide frame with burst
    spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST_EN(0)) dut0 (
        .clk(clk), .reset(reset), .cs_n(cs_n[0]), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
        .rw(rw), .shift_wren(sw[0]), .shift_out(so[0]), .sr_load(srl[0]), .addr_wren(aw[0]),
        .addr_inc(inc[0]), .dm_wren(dm[0]), .miso_en(me[0]), .word_cnt(wc[0]), .state(st[0]));
    spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1)) dut1 (
        .clk(clk), .reset(reset), .cs_n(cs_n[1]), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
        .rw(rw), .shift_wren(sw[1]), .shift_out(so[1]), .sr_load(srl[1]), .addr_wren(aw[1]),
        .addr_inc(inc[1]), .dm_wren(dm[1]), .miso_en(me[1]), .word_cnt(wc[1]), .state(st[1]));
    spi_slave_ctrl #(.ADDR_W(15), .DATA_W(16), .BURST_EN(1)) dut2 (
        .clk(clk), .reset(reset), .cs_n(cs_n[2]), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
        .rw(rw), .shift_wren(sw[2]), .shift_out(so[2]), .sr_load(srl[2]), .addr_wren(aw[2]),
        .addr_inc(inc[2]), .dm_wren(dm[2]), .miso_en(me[2]), .word_cnt(wc[2]), .state(st[2]));

    int c_sw[3], c_so[3], c_srl[3], c_aw[3], c_inc[3], c_dm[3], c_coin[3], c_mpos[3], viol[3];
    int last_sw[3], aw_dl[3], dm_dl[3];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (sw[d]) begin c_sw[d]++; last_sw[d] = cyc; end
            if (aw[d]) begin c_aw[d]++; aw_dl[d] = cyc - last_sw[d]; end
            if (dm[d]) begin c_dm[d]++; dm_dl[d] = cyc - last_sw[d]; end
            if (so[d]) c_so[d]++;
            if (srl[d]) c_srl[d]++;
            if (inc[d]) c_inc[d]++;
            if (inc[d] && dm[d]) c_coin[d]++;
            if (sclk_pos && me[d]) c_mpos[d]++;
            if (so[d] && !(sclk_neg && me[d])) viol[d]++;
        end
    end

    typedef struct {
        int sw; int aw; int srl; int dm; int inc; int wc; int st; int mpos;
    } exp_t;

    // Expected totals for a transaction of n SCLK bits with CS held low throughout
    function automatic exp_t model(int a, int dw, bit burst, bit r, int n);
        exp_t e;
        int hdr, data, words, first;
        e.sw = 0; e.aw = 0; e.srl = 0; e.dm = 0; e.inc = 0; e.wc = 0; e.st = 1; e.mpos = 0;
        hdr = a + 1;
        if (n < hdr) begin
            e.sw = n;
            return e;
        end
        data  = n - hdr;
        first = (data < dw) ? data : dw;
        words = burst ? data / dw : (data >= dw ? 1 : 0);
        e.aw  = 1;
        e.wc  = (words > 255) ? 255 : words;
        e.inc = burst ? words : 0;
        if (r) begin
            e.sw   = hdr;
            e.srl  = burst ? 1 + words : 1;
            e.mpos = burst ? data : first;
            e.st   = (!burst && words > 0) ? 7 : 4;
        end else begin
            e.sw = burst ? n : hdr + first;
            e.dm = words;
            e.st = (!burst && words > 0) ? 7 : 5;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 3; d++) begin
            c_sw[d] = 0; c_so[d] = 0; c_srl[d] = 0; c_aw[d] = 0; c_inc[d] = 0;
            c_dm[d] = 0; c_coin[d] = 0; c_mpos[d] = 0; viol[d] = 0;
            last_sw[d] = 0; aw_dl[d] = -1; dm_dl[d] = -1;
        end
    endtask

    task automatic bit_pulse();
        @(posedge clk); #1 sclk_pos = 1'b1;
        @(posedge clk); #1 sclk_pos = 1'b0;
        @(posedge clk); #1 sclk_neg = 1'b1;
        @(posedge clk); #1 sclk_neg = 1'b0;
    endtask

    task automatic run_txn(input int d, input bit r, input int n);
        clear_counts();
        rw = r;
        @(posedge clk); #1 cs_n[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) bit_pulse();
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic end_txn(input int d, input string tag);
        @(posedge clk); #1 cs_n[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " state after cs_n high"}, int'(st[d]), 0);
    endtask

    task automatic check_model(input int d, input int a, input int dw, input bit burst,
                               input bit r, input int n, input string tag);
        exp_t e;
        e = model(a, dw, burst, r, n);
        chk({tag, " shift_wren count"}, c_sw[d], e.sw);
        chk({tag, " addr_wren count"}, c_aw[d], e.aw);
        chk({tag, " sr_load count"}, c_srl[d], e.srl);
        chk({tag, " dm_wren count"}, c_dm[d], e.dm);
        chk({tag, " addr_inc count"}, c_inc[d], e.inc);
        chk({tag, " word_cnt"}, int'(wc[d]), e.wc);
        chk({tag, " state"}, int'(st[d]), e.st);
        chk({tag, " miso_en data bits"}, c_mpos[d], e.mpos);
        chk({tag, " shift_out gating"}, viol[d], 0);
    endtask

    initial begin
        int d, n;
        bit r;
        clear_counts();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset state dut%0d", i), int'(st[i]), 0);
            chk($sformatf("reset word_cnt dut%0d", i), int'(wc[i]), 0);
        end

        // Reset in the middle of the third word of a burst read
        run_txn(1, 1'b1, 8 + 16 + 3);
        chk("midread state", int'(st[1]), 4);
        chk("midread word_cnt", int'(wc[1]), 2);
        @(posedge clk); #1 reset = 1'b1; cs_n[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset midread state", int'(st[1]), 0);
        chk("reset midread word_cnt", int'(wc[1]), 0);
        chk("reset midread enables", int'({sw[1], so[1], srl[1], aw[1], inc[1], dm[1], me[1]}), 0);
        #1 reset = 1'b0;

        // Single write, no burst
        run_txn(0, 1'b0, 16);
        check_model(0, 7, 8, 1'b0, 1'b0, 16, "single write");
        chk("single write addr_wren delay", aw_dl[0], 1);
        chk("single write dm_wren delay", dm_dl[0], 1);
        for (int i = 0; i < 10; i++) bit_pulse();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("extra pulses shift_wren", c_sw[0], 16);
        chk("extra pulses dm_wren", c_dm[0], 1);
        chk("extra pulses state", int'(st[0]), 7);
        chk("extra pulses word_cnt", int'(wc[0]), 1);
        end_txn(0, "single write");

        // Single read, no burst
        run_txn(0, 1'b1, 16);
        check_model(0, 7, 8, 1'b0, 1'b1, 16, "single read");
        chk("single read shift_out count", c_so[0], 7);
        end_txn(0, "single read");

        // Burst write of three words
        run_txn(1, 1'b0, 8 + 24);
        check_model(1, 7, 8, 1'b1, 1'b0, 32, "burst write");
        chk("burst write inc with dm", c_coin[1], 3);
        end_txn(1, "burst write");

        // Abort after four data bits
        run_txn(1, 1'b0, 8 + 4);
        end_txn(1, "abort");
        chk("abort dm_wren", c_dm[1], 0);
        chk("abort addr_inc", c_inc[1], 0);

        // Randomized transactions, including headers cut short
        for (int i = 0; i < 10; i++) begin
            d = $urandom_range(0, 1);
            r = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 8 + 3 * 8 + 4);
            run_txn(d, r, n);
            check_model(d, 7, 8, (d == 1), r, n, $sformatf("rand%0d d%0d rw%0d n%0d", i, d, r, n));
            end_txn(d, $sformatf("rand%0d", i));
        end

        // Wide frame: 16-bit header, 260 burst words of 16 bits
        run_txn(2, 1'b0, 16 + 260 * 16);
        check_model(2, 15, 16, 1'b1, 1'b0, 16 + 260 * 16, "wide burst");
        chk("wide addr_wren delay", aw_dl[2], 1);
        chk("wide dm_wren delay", dm_dl[2], 1);
        end_txn(2, "wide burst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
